// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared FSM state type and sizing constants for dmem_responder
package dmem_pkg;

  localparam int WORD_W      = 32;
  localparam int DEPTH_DEF   = 32;
  localparam int LATENCY_DEF = 2;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic even_par(input logic [WORD_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with registered read port
// DMEM_PARITY_EN adds one even-parity bit per word and a par_flip_i fault-injection input.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int  DEPTH = DEPTH_DEF,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic              rd_en_i,
  input  logic              rd_clr_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [WORD_W-1:0] wdata_i,
`ifdef DMEM_PARITY_EN
  input  logic              par_flip_i,
`endif
  output logic [WORD_W-1:0] rdata_o,
  output logic              par_err_o
);

`ifdef DMEM_PARITY_EN
  localparam int ENTRY_W = WORD_W + 1;
`else
  localparam int ENTRY_W = WORD_W;
`endif

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] wentry;
  logic [ENTRY_W-1:0] rentry;
  logic [WORD_W-1:0]  rdata_q;
  logic               par_err_q;

`ifdef DMEM_PARITY_EN
  assign wentry = {even_par(wdata_i) ^ par_flip_i, wdata_i};
`else
  assign wentry = wdata_i;
`endif
  assign rentry = mem_q[idx_i];

  // Contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[idx_i] <= wentry;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q   <= '0;
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= 1'b0;
      if (rd_clr_i) begin
        rdata_q <= '0;
      end else if (rd_en_i) begin
        rdata_q <= rentry[WORD_W-1:0];
`ifdef DMEM_PARITY_EN
        par_err_q <= rentry[WORD_W] != even_par(rentry[WORD_W-1:0]);
`endif
      end
    end
  end

  assign rdata_o   = rdata_q;
  assign par_err_o = par_err_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data memory responder (FSM, latency counter, range check)
// DMEM_PARITY_EN enables per-word parity checking and the par_flip_i input.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [WORD_W-1:0] wdata_i,
`ifdef DMEM_PARITY_EN
  input  logic              par_flip_i,
`endif
  output logic              ack_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int               IDX_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [31:0]      ADDR_LIM = 32'(DEPTH * 4);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;
  logic               err_q, err_d;
`ifdef DMEM_PARITY_EN
  logic               flip_q, flip_d;
  logic               acc_flip;
`endif

  logic               enter_resp;
  logic               acc_we;
  logic [31:0]        acc_addr;
  logic [WORD_W-1:0]  acc_wdata;
  logic               acc_addr_err;
  logic               par_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
`ifdef DMEM_PARITY_EN
      flip_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
`ifdef DMEM_PARITY_EN
      flip_q  <= flip_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;
`ifdef DMEM_PARITY_EN
    flip_d     = flip_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
`ifdef DMEM_PARITY_EN
          flip_d  = par_flip_i;
`endif
          cnt_d   = CNT_LOAD;
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // With LATENCY=1 the array is accessed on the capture edge, so IDLE uses the live inputs.
  assign acc_we    = (state_q == IDLE) ? we_i    : we_q;
  assign acc_addr  = (state_q == IDLE) ? addr_i  : addr_q;
  assign acc_wdata = (state_q == IDLE) ? wdata_i : wdata_q;
`ifdef DMEM_PARITY_EN
  assign acc_flip  = (state_q == IDLE) ? par_flip_i : flip_q;
`endif

  assign acc_addr_err = (acc_addr[1:0] != 2'b00) || (acc_addr >= ADDR_LIM);
  assign err_d        = enter_resp & acc_addr_err;

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (enter_resp & acc_we & ~acc_addr_err),
    .rd_en_i   (enter_resp & ~acc_we & ~acc_addr_err),
    .rd_clr_i  (enter_resp & acc_addr_err),
    .idx_i     (acc_addr[IDX_W+1:2]),
    .wdata_i   (acc_wdata),
`ifdef DMEM_PARITY_EN
    .par_flip_i(acc_flip),
`endif
    .rdata_o   (rdata_o),
    .par_err_o (par_err)
  );

  assign ack_o  = (state_q == RESP);
  assign busy_o = (state_q != IDLE);
  assign err_o  = ack_o & (err_q | par_err);

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed vector bench for dmem_responder (DEPTH=32, LATENCY=2)
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic        busy;
  logic        err;
  logic [31:0] rdata;
`ifdef DMEM_PARITY_EN
  logic        par_flip;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  logic err_wo_ack = 1'b0;
  logic [31:0] model [32];

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vq[$];

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH  (32),
    .LATENCY(2)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .we_i      (we),
    .addr_i    (addr),
    .wdata_i   (wdata),
`ifdef DMEM_PARITY_EN
    .par_flip_i(par_flip),
`endif
    .ack_o     (ack),
    .rdata_o   (rdata),
    .busy_o    (busy),
    .err_o     (err)
  );

  always @(negedge clk) if (err && !ack) err_wo_ack = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic e, input logic [31:0] r);
    vec_t v;
    v.name = n; v.we = w; v.addr = a; v.wdata = d; v.exp_err = e; v.exp_rdata = r;
    vq.push_back(v);
  endtask

  // One request pulse; ack_at is the cycle after acceptance where ack appeared (negative on a second ack).
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int ack_at, output logic e, output logic [31:0] r);
    ack_at = 0; e = 1'b0; r = '0;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (ack) begin
        if (ack_at == 0) begin
          ack_at = k; e = err; r = rdata;
        end else begin
          ack_at = -k;
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int          ack_at;
    logic        e;
    logic [31:0] r;
    int          acks;
    int          busy_cnt;
    int          busy_bad;
    int          rd_bad;

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
`ifdef DMEM_PARITY_EN
    par_flip = 1'b0;
`endif
    #1;
    check("reset_ack",   32'(ack),  32'd0);
    check("reset_busy",  32'(busy), 32'd0);
    check("reset_err",   32'(err),  32'd0);
    check("reset_rdata", rdata,     32'd0);
    @(negedge clk);
    rst = 1'b0;

    add("st8",   1'b1, 32'h08, 32'hDEADBEEF, 1'b0, 32'h0);
    add("ld8",   1'b0, 32'h08, 32'h0,        1'b0, 32'hDEADBEEF);
    add("st4",   1'b1, 32'h04, 32'h11111111, 1'b0, 32'hDEADBEEF);
    add("ld6",   1'b0, 32'h06, 32'h0,        1'b1, 32'h0);
    add("ld4",   1'b0, 32'h04, 32'h0,        1'b0, 32'h11111111);
    add("st7c",  1'b1, 32'h7C, 32'hA5A5A5A5, 1'b0, 32'h11111111);
    add("ld7c",  1'b0, 32'h7C, 32'h0,        1'b0, 32'hA5A5A5A5);
    add("ld80",  1'b0, 32'h80, 32'h0,        1'b1, 32'h0);
    add("st0",   1'b1, 32'h00, 32'hCAFEF00D, 1'b0, 32'h0);
    add("ld0a",  1'b0, 32'h00, 32'h0,        1'b0, 32'hCAFEF00D);
    add("st1",   1'b1, 32'h01, 32'h12345678, 1'b1, 32'h0);
    add("ld0b",  1'b0, 32'h00, 32'h0,        1'b0, 32'hCAFEF00D);
    add("st80",  1'b1, 32'h80, 32'hFFFFFFFF, 1'b1, 32'h0);
    add("st10",  1'b1, 32'h10, 32'h0BADC0DE, 1'b0, 32'h0);
    add("ld10",  1'b0, 32'h10, 32'h0,        1'b0, 32'h0BADC0DE);
    add("ld4b",  1'b0, 32'h04, 32'h0,        1'b0, 32'h11111111);

    foreach (vq[i]) begin
      access(vq[i].we, vq[i].addr, vq[i].wdata, ack_at, e, r);
      check({vq[i].name, "_ack_cycle"}, 32'(ack_at), 32'd2);
      check({vq[i].name, "_err"},       32'(e),      32'(vq[i].exp_err));
      check({vq[i].name, "_rdata"},     r,           vq[i].exp_rdata);
      check({vq[i].name, "_held"},      rdata,       vq[i].exp_rdata);
    end

    // Fill every word, hit out-of-range addresses, then verify nothing moved.
    for (int i = 0; i < 32; i++) begin
      model[i] = 32'h1000_0000 ^ (32'(i) * 32'h0101_0101);
      access(1'b1, 32'(i * 4), model[i], ack_at, e, r);
    end
    access(1'b1, 32'h80, 32'hFFFFFFFF, ack_at, e, r);
    check("st80_fill_err", 32'(e), 32'd1);
    access(1'b1, 32'hFFFF_FFFC, 32'hFFFFFFFF, ack_at, e, r);
    check("stfffc_err", 32'(e), 32'd1);
    rd_bad = 0;
    for (int i = 0; i < 32; i++) begin
      access(1'b0, 32'(i * 4), 32'h0, ack_at, e, r);
      if (ack_at != 2 || e !== 1'b0 || r !== model[i]) rd_bad++;
    end
    check("readback_bad_words", 32'(rd_bad), 32'd0);

    // Request held high for 12 cycles.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h08;
    acks = 0; busy_cnt = 0; busy_bad = 0; rd_bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (ack) begin
        acks++;
        if (rdata !== model[2] || err !== 1'b0) rd_bad++;
      end
      if (busy) busy_cnt++;
      if (busy !== (i % 3 != 0)) busy_bad++;
      @(negedge clk);
    end
    req = 1'b0;
    check("hold_acks",      32'(acks),     32'd4);
    check("hold_busy",      32'(busy_cnt), 32'd8);
    check("hold_busy_cyc",  32'(busy_bad), 32'd0);
    check("hold_rdata",     32'(rd_bad),   32'd0);
    repeat (3) @(negedge clk);

    // Reset while a store sits in WAIT.
    req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h55555555;
    @(negedge clk);
    req = 1'b0;
    check("abort_busy_wait", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy_now",  32'(busy), 32'd0);
    check("abort_ack_now",   32'(ack),  32'd0);
    check("abort_rdata_now", rdata,     32'd0);
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("abort_no_ack", 32'(acks), 32'd0);
    access(1'b0, 32'h10, 32'h0, ack_at, e, r);
    check("abort_ld10_ack",   32'(ack_at), 32'd2);
    check("abort_ld10_rdata", r,           model[4]);

`ifdef DMEM_PARITY_EN
    par_flip = 1'b1;
    access(1'b1, 32'h0C, 32'h0000_0001, ack_at, e, r);
    par_flip = 1'b0;
    access(1'b0, 32'h0C, 32'h0, ack_at, e, r);
    check("par_flip_err",   32'(e), 32'd1);
    check("par_flip_rdata", r,      32'h0000_0001);
    access(1'b1, 32'h0C, 32'h0000_0001, ack_at, e, r);
    access(1'b0, 32'h0C, 32'h0, ack_at, e, r);
    check("par_ok_err",   32'(e), 32'd0);
    check("par_ok_rdata", r,      32'h0000_0001);
`endif

    check("err_without_ack", 32'(err_wo_ack), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
